ifetch_stage: RTL and testbench
===============================

Name: ifetch_stage

Overview:
- Instruction fetch stage directly upstream of the CONTROL decoder.
- Generates the PC and issues word reads to instruction memory over a req/rsp handshake, with at most one request outstanding.
- Captures each returned instruction in an IF/ID register and presents its fields (funct7, funct3, opcode, rd, rs1, rs2) to decode through a valid/ready handshake.
- Supports stall (decode not ready) and redirect (branch/jump flush).

Parameters:
- XLEN, 32, instruction/address width.
- PC_RESET, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.

Ports:
- clock  in  1  single clock, all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address (= pc_reg).
- imem_rsp_valid  in  1  instruction data is valid this cycle.
- imem_rsp_data  in  XLEN  fetched instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (forced to 0).
- id_valid  out  1  IF/ID register holds an instruction.
- id_ready  in  1  decode consumes the instruction this cycle.
- id_pc  out  XLEN  PC of the held instruction.
- id_instr  out  XLEN  raw instruction.
- id_opcode  out  7  id_instr[6:0].
- id_rd  out  5  id_instr[11:7].
- id_funct3  out  3  id_instr[14:12].
- id_rs1  out  5  id_instr[19:15].
- id_rs2  out  5  id_instr[24:20].
- id_funct7  out  7  id_instr[31:25].

Behaviour:
- Reset values:
  - pc_reg = PC_RESET, state = S_REQ.
  - id_valid = 0, id_pc = 0, id_instr = 0, so all field outputs read 0.
  - imem_req_valid = 0 while reset is high.
- States:
  - S_REQ: ready to issue a request.
  - S_WAIT: one request outstanding.
  - S_DROP: one outstanding request whose response must be discarded.
- imem_req_valid is combinational: state==S_REQ && !redirect_valid && (!id_valid || id_ready).
  - A fetch is issued only if the IF/ID slot is empty or is being drained this cycle, so a response always lands in an empty slot.
  - No response buffering is needed.
- S_REQ:
  - On imem_req_valid && imem_req_ready: pc_reg += 4 (modulo 2^XLEN, wraps), latch the request PC internally as pending_pc, go to S_WAIT.
  - Otherwise stay; imem_req_valid may drop while stalled.
- S_WAIT:
  - On imem_rsp_valid: id_instr <= imem_rsp_data, id_pc <= pending_pc, id_valid <= 1, go to S_REQ.
  - Response latency from memory is arbitrary, 1 cycle minimum.
- S_DROP:
  - On imem_rsp_valid: discard the data, id_* unchanged, go to S_REQ.
- IF/ID register:
  - id_valid clears on id_valid && id_ready unless a response loads it in the same cycle; in that case the load wins.
  - A held instruction is stable while id_valid && !id_ready.
- Fetch latency: request accept to id_valid high is the memory latency + 1 cycle (response registered).
- Redirect (highest priority, one cycle pulse sufficient):
  - pc_reg <= {redirect_pc[XLEN-1:2],2'b00}, id_valid <= 0.
  - Next state:
    - From S_WAIT → S_DROP, unless imem_rsp_valid is high that same cycle; then discard it and go to S_REQ.
    - From S_DROP → stays in S_DROP, unless the response arrives that cycle; then go to S_REQ.
    - From S_REQ → S_REQ. No request is issued on a redirect cycle.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: the outstanding request is forgotten. The memory model is reset by the same signal, so no response returns after reset.
- No decode of instruction legality here; unknown opcodes pass through to CONTROL.

Decomposition:
- Shared package rv_pkg:
  - Opcode constants OP_RTYPE=7'b0110011, OP_ITYPE=7'b0010011, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL.
  - Field bit-position localparams.
  - Fetch state enum {S_REQ,S_WAIT,S_DROP}.
  - Also used by CONTROL and the bench.
- One natural sub-module: ifid_reg, the valid/ready pipeline register holding id_pc/id_instr with load/drain/flush.
- PC/FSM logic stays in ifetch_stage.

Test Plan:
- Reset then stream, imem returns 0x00000033 (ADD x0) at PC 0, 0x40000033 at PC 4, 1-cycle latency, id_ready=1:
  - id_valid every other cycle.
  - id_pc 0 then 4.
  - id_funct7 0000000 then 0100000; id_opcode 0110011.
  - imem_req_addr 0,4,8.
- Stall: id_ready=0 for 5 cycles with id_valid=1:
  - imem_req_valid=0.
  - id_instr and id_pc constant.
  - pc_reg does not advance.
  - Releasing id_ready resumes fetch at the next sequential PC.
- Redirect while in S_WAIT, redirect_pc=0x103:
  - Late response (0x00007033) dropped, id_valid stays 0.
  - Next imem_req_addr=0x100.
- Redirect in the same cycle as imem_rsp_valid:
  - Response discarded.
  - State S_REQ; next request issued at redirect_pc the following cycle.
- Wrap: redirect_pc=0xFFFFFFFC:
  - Fetch at 0xFFFFFFFC then 0x00000000.
  - id_pc matches each.
- Async reset asserted mid-S_WAIT (between clock edges):
  - id_valid=0 and imem_req_valid=0 immediately.
  - After release, first request at PC_RESET.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 definitions: opcode constants, instruction field positions and the
// fetch FSM state encoding, used by fetch, CONTROL and the benches.
package rv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: holds one fetched instruction and its PC behind a
// valid/ready handshake, with load, drain and flush.
module ifid_reg #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    input  logic            drain,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    // Flush beats load; a load in the same cycle as a drain keeps the slot full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (valid && drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC generation, single-outstanding imem request FSM,
// and the IF/ID register feeding decode.
module ifetch_stage
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [6:0]      id_opcode,
    output logic [4:0]      id_rd,
    output logic [2:0]      id_funct3,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [6:0]      id_funct7
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pending_pc;
    logic            req_fire;
    logic            rsp_load;

    // Only fetch when the IF/ID slot will be empty by the time the response lands.
    assign imem_req_valid = !reset && (state == S_REQ) && !redirect_valid
                            && (!id_valid || id_ready);
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_load       = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;

    // Redirect overrides everything; an in-flight request becomes a drop unless
    // its response is retiring this very cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_REQ;
            pc_reg     <= PC_RESET;
            pending_pc <= '0;
        end else if (redirect_valid) begin
            pc_reg <= redirect_pc & ~(XLEN'(3));
            case (state)
                S_WAIT, S_DROP: state <= imem_rsp_valid ? S_REQ : S_DROP;
                default:        state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        pc_reg     <= pc_reg + XLEN'(4);
                        pending_pc <= pc_reg;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (imem_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    ifid_reg #(
        .XLEN(XLEN)
    ) u_ifid (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .load       (rsp_load),
        .load_pc    (pending_pc),
        .load_instr (imem_rsp_data),
        .drain      (id_ready),
        .valid      (id_valid),
        .pc         (id_pc),
        .instr      (id_instr)
    );

    assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
    assign id_rd     = id_instr[RD_MSB:RD_LSB];
    assign id_funct3 = id_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign id_rs1    = id_instr[RS1_MSB:RS1_LSB];
    assign id_rs2    = id_instr[RS2_MSB:RS2_LSB];
    assign id_funct7 = id_instr[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: streaming, stall, redirects, PC wrap and
// asynchronous reset, with hand-computed expected values.
module tb_ifetch_stage;
    import rv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [6:0]  id_funct7;

    int vec_count = 0;
    int err_count = 0;

    ifetch_stage #(
        .XLEN(32),
        .PC_RESET(32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_rd          (id_rd),
        .id_funct3      (id_funct3),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_funct7      (id_funct7)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        #2;
        vec_count++;
        if (imem_req_valid !== 1'b0) begin err_count++; $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        vec_count++;
        if (id_valid !== 1'b0) begin err_count++; $display("[TB] FAIL reset_id_valid: got %b expected 0", id_valid); end
        vec_count++;
        if (id_pc !== 32'h0) begin err_count++; $display("[TB] FAIL reset_id_pc: got %h expected 00000000", id_pc); end
        vec_count++;
        if ({id_instr, id_opcode, id_rd, id_funct3, id_rs1, id_rs2, id_funct7} !== '0) begin
            err_count++; $display("[TB] FAIL reset_id_fields: got instr %h opcode %b expected all zero", id_instr, id_opcode);
        end
        tick();
        tick();
        reset = 1'b0;
        #1;
        vec_count++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            err_count++; $display("[TB] FAIL reset_first_req: got valid %b addr %h expected 1 00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0033;
        #1;
        vec_count++;
        if (imem_req_valid !== 1'b0) begin err_count++; $display("[TB] FAIL stream_wait_no_req: got %b expected 0", imem_req_valid); end
        tick();
        imem_rsp_valid = 1'b0;
        vec_count++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            err_count++; $display("[TB] FAIL stream_id0: got valid %b pc %h expected 1 00000000", id_valid, id_pc);
        end
        vec_count++;
        if (id_funct7 !== 7'b0000000 || id_opcode !== OP_RTYPE) begin
            err_count++; $display("[TB] FAIL stream_fields0: got funct7 %b opcode %b expected 0000000 0110011", id_funct7, id_opcode);
        end
        vec_count++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
            err_count++; $display("[TB] FAIL stream_req1: got valid %b addr %h expected 1 00000004", imem_req_valid, imem_req_addr);
        end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h4000_0033;
        vec_count++;
        if (id_valid !== 1'b0) begin err_count++; $display("[TB] FAIL stream_gap: got id_valid %b expected 0", id_valid); end
        tick();
        imem_rsp_valid = 1'b0;
        vec_count++;
        if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_funct7 !== 7'b0100000 || id_opcode !== OP_RTYPE) begin
            err_count++; $display("[TB] FAIL stream_id1: got valid %b pc %h funct7 %b opcode %b expected 1 00000004 0100000 0110011", id_valid, id_pc, id_funct7, id_opcode);
        end
        vec_count++;
        if (imem_req_addr !== 32'h8) begin err_count++; $display("[TB] FAIL stream_req2_addr: got %h expected 00000008", imem_req_addr); end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            vec_count++;
            if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h8) begin
                err_count++; $display("[TB] FAIL stall_req cyc%0d: got valid %b addr %h expected 0 00000008", i, imem_req_valid, imem_req_addr);
            end
            vec_count++;
            if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== 32'h4000_0033) begin
                err_count++; $display("[TB] FAIL stall_hold cyc%0d: got valid %b pc %h instr %h expected 1 00000004 40000033", i, id_valid, id_pc, id_instr);
            end
            tick();
        end
        id_ready = 1'b1;
        #1;
        vec_count++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
            err_count++; $display("[TB] FAIL stall_resume: got valid %b addr %h expected 1 00000008", imem_req_valid, imem_req_addr);
        end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        tick();
        imem_rsp_valid = 1'b0;
        vec_count++;
        if (id_pc !== 32'h8 || id_opcode !== OP_ITYPE || id_rd !== 5'd1 || id_rs1 !== 5'd0 || id_rs2 !== 5'd1 || id_funct3 !== 3'd0) begin
            err_count++; $display("[TB] FAIL stall_after_fields: got pc %h opcode %b rd %0d rs1 %0d rs2 %0d funct3 %0d expected 00000008 0010011 1 0 1 0", id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_funct3);
        end
    endtask

    task automatic test_redirect_wait();
        vec_count++;
        if (imem_req_addr !== 32'hC) begin err_count++; $display("[TB] FAIL rdw_pre_addr: got %h expected 0000000C", imem_req_addr); end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        vec_count++;
        if (imem_req_valid !== 1'b0) begin err_count++; $display("[TB] FAIL rdw_no_req: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        vec_count++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
            err_count++; $display("[TB] FAIL rdw_drop_state: got req %b id_valid %b expected 0 0", imem_req_valid, id_valid);
        end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_7033;
        tick();
        imem_rsp_valid = 1'b0;
        vec_count++;
        if (id_valid !== 1'b0) begin err_count++; $display("[TB] FAIL rdw_late_rsp_dropped: got id_valid %b expected 0", id_valid); end
        vec_count++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            err_count++; $display("[TB] FAIL rdw_new_addr: got valid %b addr %h expected 1 00000100", imem_req_valid, imem_req_addr);
        end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        tick();
        imem_rsp_valid = 1'b0;
        vec_count++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h0000_0013) begin
            err_count++; $display("[TB] FAIL rdw_refetch: got valid %b pc %h instr %h expected 1 00000100 00000013", id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_redirect_same_cycle();
        vec_count++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h104) begin
            err_count++; $display("[TB] FAIL rds_pre_req: got valid %b addr %h expected 1 00000104", imem_req_valid, imem_req_addr);
        end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0513;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        vec_count++;
        if (id_valid !== 1'b0 || id_instr !== 32'h0000_0013) begin
            err_count++; $display("[TB] FAIL rds_discard: got valid %b instr %h expected 0 00000013", id_valid, id_instr);
        end
        vec_count++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            err_count++; $display("[TB] FAIL rds_next_req: got valid %b addr %h expected 1 00000200", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        #1;
        vec_count++;
        if (imem_req_valid !== 1'b0) begin err_count++; $display("[TB] FAIL wrap_redirect_no_req: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        vec_count++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            err_count++; $display("[TB] FAIL wrap_req0: got valid %b addr %h expected 1 fffffffc", imem_req_valid, imem_req_addr);
        end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0033;
        tick();
        imem_rsp_valid = 1'b0;
        vec_count++;
        if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin
            err_count++; $display("[TB] FAIL wrap_id0: got valid %b pc %h expected 1 fffffffc", id_valid, id_pc);
        end
        vec_count++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            err_count++; $display("[TB] FAIL wrap_req1: got valid %b addr %h expected 1 00000000", imem_req_valid, imem_req_addr);
        end
        tick();
        tick();
        vec_count++;
        if (id_valid !== 1'b0) begin err_count++; $display("[TB] FAIL wrap_latency2_wait: got id_valid %b expected 0", id_valid); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h4000_0033;
        tick();
        imem_rsp_valid = 1'b0;
        vec_count++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h4000_0033) begin
            err_count++; $display("[TB] FAIL wrap_id1: got valid %b pc %h instr %h expected 1 00000000 40000033", id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_async_reset();
        vec_count++;
        if (imem_req_addr !== 32'h4) begin err_count++; $display("[TB] FAIL ar_pre_addr: got %h expected 00000004", imem_req_addr); end
        tick();
        #2;
        reset = 1'b1;
        #1;
        vec_count++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            err_count++; $display("[TB] FAIL ar_immediate: got id_valid %b req_valid %b expected 0 0", id_valid, imem_req_valid);
        end
        vec_count++;
        if (id_pc !== 32'h0 || id_instr !== 32'h0) begin
            err_count++; $display("[TB] FAIL ar_id_cleared: got pc %h instr %h expected 00000000 00000000", id_pc, id_instr);
        end
        tick();
        #2;
        reset = 1'b0;
        #1;
        vec_count++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            err_count++; $display("[TB] FAIL ar_first_req: got valid %b addr %h expected 1 00000000", imem_req_valid, imem_req_addr);
        end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0063;
        tick();
        imem_rsp_valid = 1'b0;
        vec_count++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_opcode !== OP_BRANCH) begin
            err_count++; $display("[TB] FAIL ar_refetch: got valid %b pc %h opcode %b expected 1 00000000 1100011", id_valid, id_pc, id_opcode);
        end
    endtask

    initial begin
        $display("[TB] ifetch_stage directed test start");
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
